// File: rtl/act_lut_loader_interp.sv
// act_lut_loader_interp: loadable activation LUT with 2-stage interpolating lookup pipeline.
// Define ACT_LUT_READBACK_EN to add the registered rb_addr/rb_data table readback port.
module act_lut_loader_interp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ACT_LUT_READBACK_EN
  input  logic [ADDR_W:0]   rb_addr,
  output logic [DATA_W-1:0] rb_data,
`endif
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_err,
  output logic              armed,
  input  logic              z_valid,
  output logic              z_ready,
  input  logic [DATA_W-1:0] z_value,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] a
);
  localparam int ENTRIES = 2**ADDR_W + 1;
  localparam int PW = DATA_W + FRAC_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(ENTRIES - 1);
  typedef enum logic [1:0] {EMPTY, LOAD, ARMED} state_t;
  state_t            r_state;
  logic [ADDR_W:0]   r_ptr;
  logic              r_load_ready, r_load_err, r_armed;
  logic [DATA_W-1:0] r_tab [ENTRIES];
  logic              r_v1, r_a_valid;
  logic [DATA_W-1:0] r_base, r_next, r_a;
  logic [FRAC_W-1:0] r_rem;
  logic              w_beat, w_adv, w_take;
  logic [ADDR_W:0]   w_idx0, w_idx1;
  logic [DATA_W:0]   w_diff;
  logic [PW-1:0]     w_prod;
  logic [DATA_W-1:0] w_sum;
  assign load_ready = r_load_ready;
  assign load_err   = r_load_err;
  assign armed      = r_armed;
  assign a_valid    = r_a_valid;
  assign a          = r_a;
  assign w_beat  = r_load_ready & load_valid & !load_start;
  assign w_adv   = !r_a_valid | a_ready;
  assign z_ready = r_armed & w_adv;
  assign w_take  = z_valid & z_ready;
  assign w_idx0  = {1'b0, z_value[DATA_W-1:FRAC_W]};
  assign w_idx1  = w_idx0 + {{ADDR_W{1'b0}}, 1'b1};
  // Products are formed modulo 2**PW; the interpolated result always fits DATA_W, so low bits suffice.
  assign w_diff = {r_next[DATA_W-1], r_next} - {r_base[DATA_W-1], r_base};
  assign w_prod = {{(FRAC_W-1){w_diff[DATA_W]}}, w_diff} * {{DATA_W{1'b0}}, r_rem};
  assign w_sum  = r_base + DATA_W'($signed(w_prod) >>> FRAC_W);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_ptr        <= '0;
      r_load_ready <= 1'b0;
      r_load_err   <= 1'b0;
      r_armed      <= 1'b0;
    end else if (load_start) begin
      r_state      <= LOAD;
      r_ptr        <= '0;
      r_load_ready <= 1'b1;
      r_load_err   <= 1'b0;
      r_armed      <= 1'b0;
    end else if (w_beat) begin
      if (load_last && r_ptr == LAST) begin
        r_state      <= ARMED;
        r_load_ready <= 1'b0;
        r_armed      <= 1'b1;
      end else if (load_last || r_ptr == LAST) begin
        r_state      <= EMPTY;
        r_load_ready <= 1'b0;
        r_load_err   <= 1'b1;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_beat) r_tab[r_ptr] <= load_data;
  end
  // Single global stall: both stages advance together whenever the output slot frees up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_a_valid <= 1'b0;
      r_a       <= '0;
    end else if (load_start) begin
      r_v1      <= 1'b0;
      r_a_valid <= 1'b0;
    end else if (w_adv) begin
      r_v1      <= w_take;
      r_a_valid <= r_v1;
      if (w_take) begin
        r_base <= r_tab[w_idx0];
        r_next <= r_tab[w_idx1];
        r_rem  <= z_value[FRAC_W-1:0];
      end
      if (r_v1) r_a <= w_sum;
    end
  end
`ifdef ACT_LUT_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) rb_data <= '0;
    else     rb_data <= (rb_addr < (ADDR_W+1)'(ENTRIES)) ? r_tab[rb_addr] : '0;
  end
`endif
endmodule
